inv_keyschedule: RTL and testbench
==================================

// Module: inv_keyschedule
// PURPOSE
// On-the-fly reverse AES key schedule for the decryption datapath. Takes the final Nk
// words of the forward expansion (w[4(Nr+1)-Nk..4(Nr+1)-1]). Regenerates the schedule
// backwards one word per cycle and hands round keys Nr, Nr-1, ..., 0 to the inverse-cipher
// core over a valid/ready handshake. No 60-word array is held: only an 8-word window.
// Reuses RotWord, SubWord and xor32.
// PARAMETERS
// (none) - sized for AES-128/192/256; the key size is selected at run time by Nk
// PORTS
// clk       in   1    system clock; all state changes on posedge
// rst       in   1    synchronous, active-high reset
// start     in   1    begin a run; sampled only in IDLE
// Nk        in   4    key words: 4, 6 or 8; sampled with start
// last_key  in   256  final Nk words, MSW = lowest index; uses [32*Nk-1:0], rest ignored
// rk_ready  in   1    consumer accepts rk this cycle
// rk_valid  out  1    rk/rk_idx valid
// rk        out  128  round key; rk[127:96] = w[4r], rk[31:0] = w[4r+3]
// rk_idx    out  4    round number r of rk
// busy      out  1    high in every state except IDLE
// done      out  1    one-cycle pulse after round key 0 accepted
// err       out  1    sticky: start seen with illegal Nk; cleared by rst or next legal start
// BEHAVIOUR
// - Reset values: rk_valid=0, rk=0, rk_idx=0, busy=0, done=0, err=0, state=IDLE, window=0.
//   rst has priority over every other event and aborts a run mid-operation.
// - Nr = Nk+6. The window holds win[k] = w[jl+k] for k<Nk. jl is the lowest held index (6b).
// - States: IDLE, EMIT, STEP, DONE.
// - IDLE:
//   - start && Nk in {4,6,8}: load window from last_key; jl = 4(Nr+1)-Nk; r = Nr;
//     err = 0; go to EMIT.
//   - start with illegal Nk: err = 1; stay in IDLE.
// - EMIT: rk_valid = 1. rk = win[4r-jl .. 4r-jl+3] (offset 0, 2 or 4). rk and rk_idx are
//   held stable until rk_ready.
//   - Accept with r==0: go to DONE.
//   - Accept otherwise: r = r-1. If jl <= 4(r-1), stay in EMIT with the new rk next cycle.
//     Otherwise go to STEP.
// - STEP: rk_valid = 0. Each cycle, with i = jl-1+Nk:
//   - new = win[Nk-1] ^ g(win[Nk-2]), where g depends on i:
//     - i%Nk==0: SubWord(RotWord(x)) ^ Rcon[i/Nk-1]
//     - Nk==8 && i%8==4: SubWord(x)
//     - otherwise: x
//   - Shift the window up one word; win[0] = new; jl = jl-1.
//   - When jl == 4r, go to EMIT.
// - DONE: done = 1 for one cycle; go to IDLE; rk_valid = 0. start is ignored outside IDLE.
// - Cycle counts: rk_valid is high 1 cycle after the start edge.
//   - Nk=4: every accept is followed by 4 STEP cycles.
//   - Nk=6: first gap 2, then 4.
//   - Nk=8: first gap 0 (key 13 back-to-back), then 4.
// - rk_ready while rk_valid=0 has no effect. rk_ready held high drains at maximum rate.
// - Rcon table: 01,02,04,08,10,20,40,80,1b,36 in the top byte. All indexing math is on 6 bits.
// TESTING
// 1. AES-128: Nk=4, last_key[127:0]=d014f9a8_c9ee2589_e13f0cc8_b6630ca6, rk_ready=1
//    -> 11 keys, idx 10..0; idx0 = 2b7e1516_28aed2a6_abf71588_09cf4f3c; done pulses once.
// 2. AES-192: Nk=6, last_key = w[46..51] from the FIPS-197 A.2 expansion
//    -> 13 keys; gaps 2,4,4,...; idx0 = 8e73b0f7_da0e6452_c810f32b_809079e5.
// 3. AES-256: Nk=8, last_key = w[52..59] from FIPS-197 A.3
//    -> keys 14,13 on consecutive cycles; idx0 = 603deb10_15ca71be_2b73aef0_857d7781.
// 4. Backpressure: random rk_ready with a 30% duty
//    -> rk/rk_idx stable while valid&&!ready; no key skipped or repeated; same sequence as 1.
// 5. Nk=5 start -> err=1, busy=0, rk_valid=0. A following legal start -> err=0, run proceeds.
// 6. rst asserted in STEP mid-run -> next cycle all outputs 0, IDLE. A fresh start
//    reproduces test 1 exactly. A start during a run is ignored.

Source files
------------

// File: rtl/inv_keyschedule.sv
// inv_keyschedule: reverse AES key schedule, regenerates round keys Nr..0 from the final Nk words
module inv_keyschedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   Nk,
    input  logic [255:0] last_key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, EMIT, STEP, DONE} state_t;
    state_t state, state_n;
    logic [0:7][31:0] win, win_n;
    logic [5:0] jl, jl_n, i, im, iq;
    logic [3:0] nk_q, nk_n, r, r_n, rm;
    logic [2:0] off;
    logic [31:0] x, sw, g, nw;
    logic err_n, nk_ok;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, s;
        p = 8'h00;
        s = a;
        for (int k = 0; k < 8; k++) begin
            p = b[k] ? p ^ s : p;
            s = xt(s);
        end
        return p;
    endfunction

    // multiplicative inverse as a^254, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s, p;
        s = a;
        p = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] v);
        return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] v);
        return {v[23:0], v[31:24]};
    endfunction

    function automatic logic [31:0] xor32(input logic [31:0] a, input logic [31:0] b);
        return a ^ b;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd0: return 8'h01;
            4'd1: return 8'h02;
            4'd2: return 8'h04;
            4'd3: return 8'h08;
            4'd4: return 8'h10;
            4'd5: return 8'h20;
            4'd6: return 8'h40;
            4'd7: return 8'h80;
            4'd8: return 8'h1b;
            4'd9: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        nk_ok = Nk == 4'd4 || Nk == 4'd6 || Nk == 4'd8;
        off = 3'({r, 2'b00} - jl);
        i = jl + {2'b00, nk_q} - 6'd1;
        im = i % {2'b00, nk_q};
        iq = i / {2'b00, nk_q};
        x = win[3'(nk_q - 4'd2)];
        sw = subword(im == 6'd0 ? rotword(x) : x);
        g = im == 6'd0 ? xor32(sw, {rcon(4'(iq - 6'd1)), 24'h0}) : (nk_q == 4'd8 && im == 6'd4) ? sw : x;
        nw = xor32(win[3'(nk_q - 4'd1)], g);
        rm = r - 4'd1;
        rk_valid = state == EMIT;
        rk = rk_valid ? {win[off], win[off + 3'd1], win[off + 3'd2], win[off + 3'd3]} : '0;
        rk_idx = rk_valid ? r : '0;
        busy = state != IDLE;
        done = state == DONE;
    end

    always_comb begin
        state_n = state;
        win_n = win;
        jl_n = jl;
        nk_n = nk_q;
        r_n = r;
        err_n = err;
        unique case (state)
            IDLE: if (start) begin
                if (nk_ok) begin
                    state_n = EMIT;
                    win_n = last_key << {4'd8 - Nk, 5'd0};
                    jl_n = 6'd28 + {1'b0, Nk, 1'b0} + {2'b00, Nk};
                    nk_n = Nk;
                    r_n = Nk + 4'd6;
                    err_n = 1'b0;
                end else begin
                    err_n = 1'b1;
                end
            end
            EMIT: if (rk_ready) begin
                if (r == 4'd0) begin
                    state_n = DONE;
                end else begin
                    r_n = rm;
                    state_n = jl <= {rm, 2'b00} ? EMIT : STEP;
                end
            end
            STEP: begin
                win_n = {nw, win[0:6]};
                jl_n = jl - 6'd1;
                state_n = (jl - 6'd1) == {r, 2'b00} ? EMIT : STEP;
            end
            DONE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            win <= '0;
            jl <= '0;
            nk_q <= '0;
            r <= '0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            win <= win_n;
            jl <= jl_n;
            nk_q <= nk_n;
            r <= r_n;
            err <= err_n;
        end
    end
endmodule

// File: tb/tb_inv_keyschedule.sv
// tb_inv_keyschedule: scoreboard bench, expected keys come from a forward key expansion model
module tb_inv_keyschedule;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   Nk = 4'd0;
    logic [255:0] last_key = '0;
    logic         rk_ready = 1'b0;
    logic         rk_valid;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;
    logic         err;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] LAST128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int errors = 0;
    int checks = 0;
    logic [7:0]   sb [256];
    logic [31:0]  w [60];
    logic [131:0] q [$];

    always #5 clk = ~clk;

    inv_keyschedule dut (
        .clk(clk), .rst(rst), .start(start), .Nk(Nk), .last_key(last_key),
        .rk_ready(rk_ready), .rk_valid(rk_valid), .rk(rk), .rk_idx(rk_idx),
        .busy(busy), .done(done), .err(err)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00;
        aa = a;
        bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(a), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ c[b];
            sb[a] = s;
        end
    endtask

    function automatic logic [31:0] sub4(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    task automatic expand(input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int k = 0; k < nk; k++) w[k] = key[255 - 32 * k -: 32];
        for (int k = nk; k < 4 * (nk + 7); k++) begin
            t = w[k - 1];
            if (k % nk == 0) begin
                t = sub4({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && k % nk == 4) begin
                t = sub4(t);
            end
            w[k] = w[k - nk] ^ t;
        end
    endtask

    function automatic logic [255:0] mk_lk(input int nk);
        logic [255:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < nk; k++) v[32 * (nk - k) - 1 -: 32] = w[3 * nk + 28 + k];
        return v;
    endfunction

    task automatic load_exp(input int nk);
        q.delete();
        for (int r = nk + 6; r >= 0; r--) q.push_back({4'(r), w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]});
    endtask

    task automatic kick(input int nk, input logic [255:0] lk);
        start = 1'b1;
        Nk = 4'(nk);
        last_key = lk;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int nk, input int pct, input bit gapchk, input string name);
        int cyc, nacc, last, dcnt, ge;
        bit held;
        logic [131:0] prev, e;
        cyc = 0; nacc = 0; last = 0; dcnt = 0; held = 1'b0; prev = '0;
        while (q.size() > 0 && cyc < 3000) begin
            if (done) dcnt++;
            if (held) begin
                checks++;
                if (rk_valid !== 1'b1 || {rk_idx, rk} !== prev) begin
                    errors++;
                    $display("FAIL %s hold: got v=%b %h exp %h", name, rk_valid, {rk_idx, rk}, prev);
                end
            end
            rk_ready = ($urandom_range(99) < pct);
            if (rk_valid && rk_ready) begin
                e = q.pop_front();
                checks++;
                if ({rk_idx, rk} !== e) begin
                    errors++;
                    $display("FAIL %s key: got %h exp %h", name, {rk_idx, rk}, e);
                end
                if (gapchk && nacc > 0) begin
                    ge = (nk == 4) ? 4 : (nacc == 1) ? ((nk == 6) ? 2 : 0) : 4;
                    checks++;
                    if (cyc - last - 1 != ge) begin
                        errors++;
                        $display("FAIL %s gap: got %0d exp %0d after key %0d", name, cyc - last - 1, ge, nacc);
                    end
                end
                last = cyc;
                nacc++;
            end
            held = rk_valid && !rk_ready;
            prev = {rk_idx, rk};
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        rk_ready = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: got %0d keys left exp 0", name, q.size());
            q.delete();
        end
        checks++;
        if (done !== 1'b1 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b v=%b exp done=1 v=0", name, done, rk_valid);
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL %s early_done: got %0d exp 0", name, dcnt);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: got done=%b busy=%b exp 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rk_valid, rk, rk_idx, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset: got v=%b rk=%h idx=%h busy=%b done=%b err=%b exp all 0", rk_valid, rk, rk_idx, busy, done, err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_aes128();
        expand(4, KEY128);
        load_exp(4);
        kick(4, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} & {128'h0 - 128'h1, 128'h0} | {128'h0, LAST128});
        checks++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'd10 || rk !== LAST128 || busy !== 1'b1) begin
            errors++;
            $display("FAIL aes128 first: got v=%b idx=%0d rk=%h busy=%b exp 1 10 %h 1", rk_valid, rk_idx, rk, busy, LAST128);
        end
        drain(4, 100, 1'b1, "aes128");
    endtask

    task automatic test_aes192();
        expand(6, KEY192);
        load_exp(6);
        kick(6, mk_lk(6));
        checks++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'd12) begin
            errors++;
            $display("FAIL aes192 first: got v=%b idx=%0d exp 1 12", rk_valid, rk_idx);
        end
        drain(6, 100, 1'b1, "aes192");
    endtask

    task automatic test_aes256();
        expand(8, KEY256);
        load_exp(8);
        kick(8, mk_lk(8));
        checks++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'd14) begin
            errors++;
            $display("FAIL aes256 first: got v=%b idx=%0d exp 1 14", rk_valid, rk_idx);
        end
        drain(8, 100, 1'b1, "aes256");
    endtask

    task automatic test_backpressure();
        expand(4, KEY128);
        load_exp(4);
        kick(4, mk_lk(4));
        drain(4, 30, 1'b0, "backpressure");
    endtask

    task automatic test_bad_nk();
        kick(5, mk_lk(4));
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_nk5: got err=%b busy=%b v=%b exp 1 0 0", err, busy, rk_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bad_nk rst_clears: got err=%b exp 0", err);
        end
        kick(12, mk_lk(4));
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_nk12: got err=%b busy=%b exp 1 0", err, busy);
        end
        expand(4, KEY128);
        load_exp(4);
        kick(4, mk_lk(4));
        checks++;
        if (err !== 1'b0 || rk_valid !== 1'b1) begin
            errors++;
            $display("FAIL bad_nk recover: got err=%b v=%b exp 0 1", err, rk_valid);
        end
        drain(4, 100, 1'b1, "bad_nk_run");
    endtask

    task automatic test_abort();
        expand(4, KEY128);
        load_exp(4);
        kick(4, mk_lk(4));
        start = 1'b1;
        Nk = 4'd8;
        last_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (rk_valid !== 1'b1 || {rk_idx, rk} !== q[0]) begin
            errors++;
            $display("FAIL abort ignore_start: got v=%b %h exp 1 %h", rk_valid, {rk_idx, rk}, q[0]);
        end
        rk_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rk_ready = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort in_step: got v=%b busy=%b exp 0 1", rk_valid, busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({rk_valid, rk, rk_idx, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL abort outputs: got v=%b rk=%h idx=%h busy=%b done=%b err=%b exp all 0", rk_valid, rk, rk_idx, busy, done, err);
        end
        load_exp(4);
        kick(4, mk_lk(4));
        drain(4, 100, 1'b1, "abort_rerun");
    endtask

    initial begin
        init_sbox();
        @(negedge clk);
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_bad_nk();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run exp finish");
        $fatal(1, "watchdog expired");
    end
endmodule
